// File: rtl/iob_dma_chan_sched.sv
// Multi-channel stream scheduler: N_CH length-programmed channels are merged
// round-robin, one burst at a time, onto a single AXIS master tagged with the channel id.
module iob_dma_chan_sched #(
    parameter int N_CH      = 4,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 16,
    parameter int BURST_LEN = 16,
    parameter int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk_i,
    input  logic                     arst_i,
    input  logic                     cke_i,
    input  logic                     cfg_valid_i,
    output logic                     cfg_ready_o,
    input  logic [CH_W-1:0]          cfg_ch_i,
    input  logic [LEN_W-1:0]         cfg_len_i,
    input  logic [N_CH-1:0]          abort_i,
    input  logic [N_CH-1:0]          irq_clr_i,
    input  logic [N_CH*DATA_W-1:0]   s_tdata_i,
    input  logic [N_CH-1:0]          s_tvalid_i,
    output logic [N_CH-1:0]          s_tready_o,
    output logic [DATA_W-1:0]        m_tdata_o,
    output logic                     m_tvalid_o,
    input  logic                     m_tready_i,
    output logic                     m_tlast_o,
    output logic [CH_W-1:0]          m_tch_o,
    output logic [N_CH-1:0]          busy_o,
    output logic [N_CH-1:0]          done_o,
    output logic                     irq_o
);

    typedef enum logic {ST_ARB, ST_BURST} state_t;

    localparam logic [LEN_W-1:0] BL = LEN_W'(BURST_LEN);

    state_t                      state_q, state_d;
    logic [N_CH-1:0][LEN_W-1:0]  rem_q, rem_d;
    logic [N_CH-1:0]             flag_q, flag_d;
    logic [N_CH-1:0]             done_q, done_d;
    logic [CH_W-1:0]             grant_q, grant_d;
    logic [CH_W-1:0]             last_q, last_d;
    logic [LEN_W-1:0]            blen_q, blen_d;
    logic [LEN_W-1:0]            beat_q, beat_d;
    logic                        pend_q, pend_d;

    logic                        cfg_acc, hs, last_beat, found;

    always_comb begin
        cfg_ready_o = 1'b1;
        for (int c = 0; c < N_CH; c++) begin
            busy_o[c] = |rem_q[c];
            if (cfg_ch_i == CH_W'(c)) cfg_ready_o = ~(|rem_q[c]);
        end
    end

    // Zero-latency mux of the granted channel; idle or frozen means no handshakes at all.
    always_comb begin
        m_tdata_o  = '0;
        m_tvalid_o = 1'b0;
        s_tready_o = '0;
        m_tch_o    = '0;
        m_tlast_o  = 1'b0;
        if (state_q == ST_BURST) begin
            m_tch_o   = grant_q;
            m_tlast_o = (beat_q == blen_q - LEN_W'(1));
            for (int c = 0; c < N_CH; c++) begin
                if (grant_q == CH_W'(c)) begin
                    m_tdata_o = s_tdata_i[c*DATA_W +: DATA_W];
                    if (cke_i) begin
                        m_tvalid_o    = s_tvalid_i[c];
                        s_tready_o[c] = m_tready_i;
                    end
                end
            end
        end
    end

    assign cfg_acc   = cfg_valid_i & cfg_ready_o;
    assign hs        = m_tvalid_o & m_tready_i;
    assign last_beat = hs & m_tlast_o;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        grant_d = grant_q;
        last_d  = last_q;
        blen_d  = blen_q;
        beat_d  = beat_q;
        pend_d  = pend_q;
        done_d  = '0;
        found   = 1'b0;

        for (int c = 0; c < N_CH; c++) begin
            if (cfg_acc && cfg_ch_i == CH_W'(c) && !abort_i[c]) begin
                rem_d[c]  = cfg_len_i;
                done_d[c] = (cfg_len_i == '0);
            end
            // The granted channel's abort waits for the end of its announced burst.
            if (abort_i[c] && !(state_q == ST_BURST && grant_q == CH_W'(c)))
                rem_d[c] = '0;
        end

        case (state_q)
            ST_ARB: begin
                for (int c = 0; c < N_CH; c++) begin
                    if (!found && CH_W'(c) > last_q && rem_q[c] != '0 && !abort_i[c]) begin
                        found   = 1'b1;
                        grant_d = CH_W'(c);
                        blen_d  = (rem_q[c] < BL) ? rem_q[c] : BL;
                    end
                end
                for (int c = 0; c < N_CH; c++) begin
                    if (!found && CH_W'(c) <= last_q && rem_q[c] != '0 && !abort_i[c]) begin
                        found   = 1'b1;
                        grant_d = CH_W'(c);
                        blen_d  = (rem_q[c] < BL) ? rem_q[c] : BL;
                    end
                end
                if (found) begin
                    state_d = ST_BURST;
                    beat_d  = '0;
                    pend_d  = 1'b0;
                end
            end
            ST_BURST: begin
                for (int c = 0; c < N_CH; c++) begin
                    if (grant_q == CH_W'(c)) begin
                        pend_d = pend_q | abort_i[c];
                        if (hs) begin
                            beat_d   = beat_q + LEN_W'(1);
                            rem_d[c] = rem_q[c] - LEN_W'(1);
                            if (last_beat) begin
                                state_d = ST_ARB;
                                last_d  = grant_q;
                                if (pend_q || abort_i[c])
                                    rem_d[c] = '0;
                                else if (rem_q[c] == LEN_W'(1))
                                    done_d[c] = 1'b1;
                            end
                        end
                    end
                end
            end
            default: state_d = ST_ARB;
        endcase

        flag_d = (flag_q & ~irq_clr_i) | done_d;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= ST_ARB;
            rem_q   <= '0;
            flag_q  <= '0;
            done_q  <= '0;
            grant_q <= '0;
            last_q  <= CH_W'(N_CH - 1);
            blen_q  <= '0;
            beat_q  <= '0;
            pend_q  <= 1'b0;
        end else if (cke_i) begin
            state_q <= state_d;
            rem_q   <= rem_d;
            flag_q  <= flag_d;
            done_q  <= done_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            blen_q  <= blen_d;
            beat_q  <= beat_d;
            pend_q  <= pend_d;
        end
    end

    assign done_o = done_q;
    assign irq_o  = |flag_q;

endmodule

// File: doc/iob_dma_chan_sched.md
# iob_dma_chan_sched

Parametrised multi-channel stream scheduler for the next-generation DMA. It replaces the single selected AXIS input with N_CH independently programmed channels. Each channel has its own transfer length, busy/done status and abort. Active channels are time-multiplexed onto one AXIS master toward the shared AXI burst engine. Grants are round-robin at burst granularity, and every burst is tagged with its channel id and a last-beat flag.

## Interface
- N_CH, 4: number of stream channels (≥1); CH_W = max(1, $clog2(N_CH)).
- DATA_W, 32: stream data width.
- LEN_W, 16: transfer length width, in words.
- BURST_LEN, 16: maximum beats per granted burst (≥1).

- clk_i  in  1  clock; all state updates on rising edge.
- arst_i  in  1  asynchronous active-high reset.
- cke_i  in  1  clock enable; 0 freezes all registers.
- cfg_valid_i  in  1  start-transfer request.
- cfg_ready_o  out  1  = ~busy_o[cfg_ch_i]; 1 when cfg_ch_i ≥ N_CH.
- cfg_ch_i  in  CH_W  target channel.
- cfg_len_i  in  LEN_W  transfer length in words.
- abort_i  in  N_CH  per-channel abort, sampled each cycle.
- irq_clr_i  in  N_CH  clears the sticky done flags.
- s_tdata_i  in  N_CH*DATA_W  channel c data at bits [c*DATA_W +: DATA_W].
- s_tvalid_i  in  N_CH  per-channel valid.
- s_tready_o  out  N_CH  per-channel ready.
- m_tdata_o  out  DATA_W  merged stream data.
- m_tvalid_o  out  1  merged valid.
- m_tready_i  in  1  merged ready.
- m_tlast_o  out  1  last beat of the current burst.
- m_tch_o  out  CH_W  channel owning the current beat.
- busy_o  out  N_CH  channel has remaining words.
- done_o  out  N_CH  one-cycle completion pulse.
- irq_o  out  1  OR of sticky done flags.

## Operation
- Per-channel state: rem[c] (LEN_W bits), busy = rem≠0, sticky done flag.
- Config:
  - Accepted on cfg_valid_i & cfg_ready_o & cke_i; loads rem[cfg_ch_i] = cfg_len_i.
  - cfg_len_i = 0: accepted, no data moved, done_o pulses the following cycle.
  - cfg_ch_i ≥ N_CH: handshake completes, request is discarded.
- FSM has two states, ARB and BURST.
- ARB:
  - Selects the first channel c with rem[c]≠0, scanning cyclically from last_grant+1.
  - If one is found: registers grant = c and blen = min(BURST_LEN, rem[c]), then moves to BURST.
  - Otherwise stays in ARB.
- BURST:
  - Combinational pass-through of the granted channel: m_tdata_o = s_tdata_i[grant], m_tvalid_o = s_tvalid_i[grant], s_tready_o[grant] = m_tready_i. All other s_tready_o are 0.
  - m_tch_o = grant.
  - m_tlast_o = 1 when beat counter = blen-1.
  - Each handshake decrements rem[grant] and increments the beat counter.
  - Handshake on the last beat: last_grant = grant, return to ARB. If rem reaches 0, done_o[grant] pulses the next cycle and the sticky flag is set.
- Outside BURST: m_tvalid_o = 0, s_tready_o = 0, m_tlast_o = 0.
- Abort:
  - Idle channel: ignored.
  - Busy, non-granted channel: rem cleared next cycle, no done_o.
  - Granted channel mid-burst: deferred until the burst's last-beat handshake. Downstream burst length always equals the announced blen. rem is then cleared and no done_o is issued.
  - Abort and an accepted cfg on the same channel in the same cycle: abort wins and rem stays 0.
- Sticky flags:
  - irq_clr_i[c] clears flag c.
  - Set and clear in the same cycle: set wins.
- cke_i = 0: registers hold; m_tvalid_o and s_tready_o forced to 0.

## Timing
- Reset values:
  - Outputs: all 0, except cfg_ready_o = 1.
  - Internal: rem = 0, FSM = ARB, last_grant = N_CH-1 (channel 0 wins first).
- Config accepted at edge k: busy_o high after k. The channel is eligible in ARB from cycle k+1, and the first beat can be offered at cycle k+2.
- One idle ARB cycle separates consecutive bursts. Throughput is blen/(blen+1) beats/cycle under full valid/ready.
- Data path has zero latency: no registers between s_* and m_* in BURST.
- done_o is a single pulse, registered one cycle after the completing handshake.
- Reset asserted mid-burst aborts everything immediately and issues no done_o.

## Test plan
- Single channel: cfg ch0 len=5, BURST_LEN=16, constant valid/ready -> 5 beats with m_tch_o=0 and m_tlast_o on beat 5; done_o[0] pulses one cycle later; irq_o=1 until irq_clr_i[0].
- Round-robin: ch0 len=40 and ch2 len=20, BURST_LEN=16 -> bursts ch0:16, ch2:16, ch0:16, ch2:4, ch0:8; ARB gap of 1 cycle between each; done_o[2] before done_o[0].
- Back-pressure: random m_tready_i and s_tvalid_i on ch1 len=33 -> data order preserved, bursts 16/16/1, s_tready_o of non-granted channels always 0.
- Abort: ch0 len=32 and ch1 len=32; abort ch0 at its beat 4 and abort ch1 while it waits -> ch0 burst completes 16 beats, ch1 never granted, no done_o pulses, busy_o=0.
- Edges: cfg len=0 -> done_o after 1 cycle with no beats; cfg to a busy channel -> cfg_ready_o=0, not accepted; cfg_ch_i=N_CH -> ignored.
- Reset mid-burst at beat 7 -> all outputs at reset values next cycle; a new cfg after reset proceeds normally.
